// File: rtl/fcvt_w_s.sv
// Multi-cycle single-precision float to signed 32-bit integer converter (FCVT.W.S).
// Define FCVT_RNE_EN to honour rm=000 as round-to-nearest-even; otherwise always RTZ.
module fcvt_w_s (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rs1,
  input  logic [2:0]  rm,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, FINISH} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic        g_q, g_d;
  logic        st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        spec_q, spec_d;
  logic        nv_q, nv_d;
  logic [31:0] out_q, out_d;
  logic        done_q, done_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;

  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic        rnd_inc;
  logic [31:0] mag_rnd;

  assign exp_f = op_q[30:23];
  assign frac  = op_q[22:0];

`ifdef FCVT_RNE_EN
  logic [2:0] rm_q, rm_d;
  assign rnd_inc = (rm_q == 3'b000) & g_q & (st_q | mag_q[0]);
`else
  logic unused_rm;
  assign unused_rm = ^rm;
  assign rnd_inc   = 1'b0;
`endif

  assign mag_rnd = mag_q + {31'd0, rnd_inc};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    g_d       = g_q;
    st_d      = st_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    spec_d    = spec_q;
    nv_d      = nv_q;
    out_d     = out_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
`ifdef FCVT_RNE_EN
    rm_d      = rm_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = rs1;
`ifdef FCVT_RNE_EN
          rm_d    = rm;
`endif
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d  = op_q[31];
        mag_d   = '0;
        g_d     = 1'b0;
        st_d    = 1'b0;
        cnt_d   = '0;
        left_d  = 1'b0;
        spec_d  = 1'b0;
        nv_d    = 1'b0;
        state_d = FINISH;
        // Special results are parked in mag and passed through FINISH unnegated.
        if (exp_f == 8'd255) begin
          spec_d = 1'b1;
          nv_d   = 1'b1;
          mag_d  = ((frac != '0) || !op_q[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (exp_f >= 8'd158) begin
          spec_d = 1'b1;
          if (op_q[31]) begin
            mag_d = 32'h8000_0000;
            nv_d  = (exp_f != 8'd158) || (frac != '0);
          end else begin
            mag_d = 32'h7FFF_FFFF;
            nv_d  = 1'b1;
          end
        end else if (exp_f == 8'd0) begin
          st_d = |frac;
        end else if (exp_f <= 8'd125) begin
          st_d = 1'b1;
        end else if (exp_f == 8'd126) begin
          g_d  = 1'b1;
          st_d = |frac;
        end else begin
          mag_d = {8'd0, 1'b1, frac};
          if (exp_f < 8'd150) begin
            cnt_d   = 5'(8'd150 - exp_f);
            state_d = SHIFT;
          end else if (exp_f > 8'd150) begin
            cnt_d   = 5'(exp_f - 8'd150);
            left_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          g_d   = mag_q[0];
          st_d  = st_q | g_q;
          mag_d = mag_q >> 1;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = FINISH;
      end
      FINISH: begin
        done_d    = 1'b1;
        invalid_d = nv_q;
        state_d   = IDLE;
        if (spec_q) begin
          out_d     = mag_q;
          inexact_d = 1'b0;
        end else begin
          out_d     = sign_q ? (~mag_rnd + 32'd1) : mag_rnd;
          inexact_d = g_q | st_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      g_q       <= 1'b0;
      st_q      <= 1'b0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      spec_q    <= 1'b0;
      nv_q      <= 1'b0;
      out_q     <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
`ifdef FCVT_RNE_EN
      rm_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      g_q       <= g_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      spec_q    <= spec_d;
      nv_q      <= nv_d;
      out_q     <= out_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
`ifdef FCVT_RNE_EN
      rm_q      <= rm_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign out     = out_q;
  assign invalid = invalid_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_fcvt_w_s.sv
// Scoreboard bench for fcvt_w_s: driver queues expected results, a negedge monitor checks each done.
module tb_fcvt_w_s;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rs1 = '0;
  logic [2:0]  rm = '0;
  logic        busy, done, invalid, inexact;
  logic [31:0] out;

  fcvt_w_s dut (
    .clk(clk), .reset(reset), .start(start), .rs1(rs1), .rm(rm),
    .busy(busy), .done(done), .out(out), .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        nv;
    logic        nx;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

`ifdef FCVT_RNE_EN
  localparam logic [31:0] R25 = 32'd2, R35 = 32'd4, R15 = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] R25 = 32'd2, R35 = 32'd3, R15 = 32'hFFFF_FFFF;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=none", out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", out, e.res);
        chk("invalid", {31'd0, invalid}, {31'd0, e.nv});
        chk("inexact", {31'd0, inexact}, {31'd0, e.nx});
        if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] m, input bit push,
                       input logic [31:0] res, input logic nv, input logic nx, input int lat);
    exp_t e;
    start = 1'b1;
    rs1   = a;
    rm    = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs1   = $urandom;
    rm    = 3'($urandom);
    if (push) begin
      e.res = res; e.nv = nv; e.nx = nx; e.lat = lat; e.t0 = cyc;
      q.push_back(e);
    end
  endtask

  // Returns at the negedge of the done cycle so the next start lands in that cycle.
  task automatic wait_done();
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=no_done required=done");
    end else begin
      chk("busy_during", {31'd0, busy_ok}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [2:0] m, input logic [31:0] res,
                     input logic nv, input logic nx, input int lat);
    issue(a, m, 1'b1, res, nv, nx, lat);
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_flags", {30'd0, invalid, inexact}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(32'h4049_0FDB, 3'b001, 32'h0000_0003, 1'b0, 1'b1, 24);
    run(32'hC2F6_0000, 3'b000, 32'hFFFF_FF85, 1'b0, 1'b0, 19);
    run(32'h4B7F_FFFF, 3'b000, 32'h00FF_FFFF, 1'b0, 1'b0, 2);
    run(32'h4EFF_FFFF, 3'b000, 32'h7FFF_FF80, 1'b0, 1'b0, 9);
    run(32'h4F00_0000, 3'b000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run(32'hCF00_0000, 3'b000, 32'h8000_0000, 1'b0, 1'b0, 2);
    run(32'h7FC0_0000, 3'b000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run(32'hFF80_0000, 3'b000, 32'h8000_0000, 1'b1, 1'b0, 2);
    run(32'h7F80_0000, 3'b000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run(32'h8000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run(32'hCF00_0001, 3'b000, 32'h8000_0000, 1'b1, 1'b0, 2);

    run(32'h4020_0000, 3'b000, R25, 1'b0, 1'b1, 24);
    run(32'h4060_0000, 3'b000, R35, 1'b0, 1'b1, 24);
    run(32'h3F00_0000, 3'b000, 32'd0, 1'b0, 1'b1, 2);
    run(32'hBFC0_0000, 3'b000, R15, 1'b0, 1'b1, 25);
    run(32'h4060_0000, 3'b001, 32'd3, 1'b0, 1'b1, 24);
    run(32'hBFC0_0000, 3'b001, 32'hFFFF_FFFF, 1'b0, 1'b1, 25);
    run(32'h0000_0001, 3'b000, 32'd0, 1'b0, 1'b1, 2);
    run(32'h3E80_0000, 3'b000, 32'd0, 1'b0, 1'b1, 2);

    // start while busy must be ignored
    issue(32'h4049_0FDB, 3'b000, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 24);
    repeat (3) @(negedge clk);
    start = 1'b1;
    rs1   = 32'h4F00_0000;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    // reset mid-SHIFT aborts with no done
    issue(32'h4049_0FDB, 3'b000, 1'b0, '0, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out", out, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    run(32'hC2F6_0000, 3'b000, 32'hFFFF_FF85, 1'b0, 1'b0, 19);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcvt_w_s.md
Name: fcvt_w_s

Overview:
- Multi-cycle converter from IEEE-754 single precision to signed 32-bit integer (RISC-V FCVT.W.S). Inverse of the integer-to-float unit.
- Sits beside the FP execute path, driven by a start/done handshake from the issue logic.
- Shifts the significand one bit per cycle to keep area small. Reports NV (invalid) and NX (inexact) flags.

Parameters:
- none (fixed 32-bit operand/result)

Ports:
- clk      input   1   clock, rising edge
- reset    input   1   asynchronous, active-high reset
- start    input   1   request; sampled only when busy=0
- rs1      input   32  float operand, captured on the accepted start edge
- rm       input   3   rounding mode; used only with FCVT_RNE_EN
- busy     output  1   high while a conversion is in flight
- done     output  1   one-cycle pulse; out/invalid/inexact valid from this cycle
- out      output  32  signed integer result, held until the next done
- invalid  output  1   NV flag for the last conversion
- inexact  output  1   NX flag for the last conversion

Behaviour:
- Reset (async, any state):
  - state=IDLE; out=0, done=0, busy=0, invalid=0, inexact=0.
  - An in-flight conversion is aborted and produces no done.
- busy = (state != IDLE). done is registered, high only in the cycle after the FINISH edge.
- States: IDLE, UNPACK, SHIFT, FINISH.
- IDLE: start=1 at edge T captures rs1 and moves to UNPACK. start while busy is ignored. A start asserted during the done cycle is accepted.
- UNPACK (edge T+1): s=rs1[31], E=rs1[30:23], F=rs1[22:0], e=E-127, sig={1,F} (24b). Compute mag, k, guard (g), sticky (st):
  - E=255, F!=0 (NaN): result 0x7FFFFFFF, invalid=1.
  - E=255, F=0: +inf gives 0x7FFFFFFF, -inf gives 0x80000000; invalid=1.
  - e>=31: if s=1, E=158, F=0, result 0x80000000 with no flags. Otherwise saturate (s ? 0x80000000 : 0x7FFFFFFF) with invalid=1.
  - E=0 (zero/subnormal): mag=0, g=0, st=|F.
  - e<=-2: mag=0, g=0, st=1.
  - e=-1: mag=0, g=1, st=|F.
  - 0<=e<=22: mag=sig, k=23-e, right shift.
  - e=23: mag=sig, k=0.
  - 24<=e<=30: mag=sig, k=e-23, left shift.
  - All special cases and k=0 go straight to FINISH. Otherwise go to SHIFT.
- SHIFT: one bit per edge, k edges total (max 23), using a 5-bit down-counter.
  - Right shift: g <= mag[0]; st <= st|g; mag >>= 1.
  - Left shift: mag <<= 1.
  - Leaves for FINISH on the edge where the counter reaches 0.
- FINISH:
  - Apply rounding to mag. out = s ? (~mag+1) : mag. A result of -0 is 0x00000000.
  - inexact = g|st, except 0 on the saturate/NaN/inf paths. invalid as set in UNPACK.
  - Asserts done and returns to IDLE.
- Latency: done high after edge T+2+k; k=0 for special and e<=-1 paths (done after T+2). Worst case T+25.
- Width rules:
  - mag is 32 bits unsigned. Left shift never exceeds bit 30 because e<=30 on that path.
  - Rounding increment cannot overflow 32-bit signed: only e<=22 rounds, so mag<2^23.

Optional Feature:
- FCVT_RNE_EN defined:
  - rm=3'b000 selects round-to-nearest-even in FINISH: mag+=1 when g & (st | mag[0]).
  - Any other rm value selects RTZ.
- FCVT_RNE_EN undefined: always RTZ (truncate); rm is ignored. inexact is computed identically in both builds.

Test Plan:
- rs1=0x40490FDB (pi), start at edge T -> done after T+24 (k=22), out=0x00000003, inexact=1, invalid=0; busy high from T through T+23.
- rs1=0xC2F60000 (-123.0) -> out=0xFFFFFF85, inexact=0; rs1=0x4B7FFFFF -> out=0x00FFFFFF, done after T+2; rs1=0x4EFFFFFF -> out=0x7FFFFF80, done after T+9.
- Saturation:
  - 0x4F000000 -> 0x7FFFFFFF, invalid=1.
  - 0xCF000000 -> 0x80000000, invalid=0.
  - 0x7FC00000 -> 0x7FFFFFFF, invalid=1.
  - 0xFF800000 -> 0x80000000, invalid=1.
  - 0x80000000 -> 0, no flags.
- Rounding:
  - With FCVT_RNE_EN, rm=000: 0x40200000 (2.5)->2, 0x40600000 (3.5)->4, 0x3F000000 (0.5)->0, 0xBFC00000 (-1.5)->0xFFFFFFFE, all with inexact=1.
  - Without the macro (or rm=001): 2, 3, 0, 0xFFFFFFFF respectively.
  - 0x00000001 (subnormal) -> 0 with inexact=1 in both builds.
- Handshake:
  - start pulsed while busy is ignored (out is the first operand's result).
  - Back-to-back start during the done cycle is accepted.
  - reset asserted mid-SHIFT -> busy=0, done never pulses, out=0.
